// File: rtl/music_pkg.sv
// Shared types and constants for the song sequencer and its pitch table.
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PLAY,
        ST_GAP,
        ST_DONE
    } state_t;

    localparam int MS_W    = 10;
    localparam int PITCH_W = 6;

    localparam logic [PITCH_W-1:0] PITCH_END  = 6'd63;
    localparam logic [PITCH_W-1:0] PITCH_REST = 6'd0;

    // Note word layout: [15:10] pitch index, [9:0] duration in ms.
    typedef struct packed {
        logic [PITCH_W-1:0] pitch;
        logic [MS_W-1:0]    ms;
    } note_word_t;

    // Half-periods of C3..B3 in cycles of a 12 MHz system clock.
    // Higher octaves halve the value once per octave.
    localparam logic [15:0] BASE_HALF_PERIOD [12] = '{
        16'd45868, 16'd43293, 16'd40864, 16'd38570,
        16'd36406, 16'd34362, 16'd32432, 16'd30612,
        16'd28895, 16'd27273, 16'd25742, 16'd24297
    };

endpackage

// File: rtl/music_note_table.sv
// Pitch index -> tone half-period. Pitch 1 is C3, each step is one semitone;
// the rest and end-marker pitches map to 0.
module music_note_table
    import music_pkg::*;
(
    input  logic [PITCH_W-1:0] pitch,
    output logic [15:0]        half_period
);

    logic [PITCH_W-1:0] idx;
    logic [3:0]         semitone;
    logic [2:0]         octave;

    // Split the pitch into semitone and octave, then scale the base entry.
    always_comb begin
        // NOTE: every output gets a value on every path, so no latch is inferred.
        idx         = pitch - PITCH_W'(1);
        semitone    = 4'(idx % PITCH_W'(12));
        octave      = 3'(idx / PITCH_W'(12));
        half_period = BASE_HALF_PERIOD[semitone] >> octave;
        if (pitch == PITCH_REST || pitch == PITCH_END) begin
            half_period = '0;
        end
    end

endmodule

// File: rtl/music_sequencer.sv
// Song sequencer: walks a synchronous song ROM, gates the tone generator for
// each note's duration (ms x ticks_per_milli cycles) and inserts a silent gap.
module music_sequencer
    import music_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int GAP_MS = 20,
    parameter int TPM_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              loop_en,
    input  logic [TPM_W-1:0]  ticks_per_milli,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              tone_en,
    output logic [15:0]       tone_half_period,
    output logic [7:0]        led,
    output logic              busy,
    output logic              done
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic                tone_en_q, tone_en_d;
    logic [15:0]         half_q, half_d;
    logic [7:0]          led_q, led_d;
    logic                done_q, done_d;
    logic [TPM_W-1:0]    tick_q, tick_d;
    logic [TPM_W-1:0]    tpm_q, tpm_d;
    logic [MS_W-1:0]     ms_q, ms_d;

    note_word_t          word;
    logic [15:0]         table_half;
    logic [TPM_W-1:0]    tpm_eff;
    logic                tick_wrap;

    assign word      = note_word_t'(rom_data);
    assign tpm_eff   = (ticks_per_milli == '0) ? TPM_W'(1) : ticks_per_milli;
    assign tick_wrap = (tick_q == tpm_q - TPM_W'(1));

    music_note_table u_note_table (
        .pitch       (word.pitch),
        .half_period (table_half)
    );

    // Next-state and next-output logic for the playback FSM and its counters.
    always_comb begin
        state_d    = state_q;
        rom_addr_d = rom_addr_q;
        tone_en_d  = tone_en_q;
        half_d     = half_q;
        led_d      = led_q;
        done_d     = 1'b0;
        tick_d     = tick_q;
        tpm_d      = tpm_q;
        ms_d       = ms_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FETCH;
                    rom_addr_d = '0;
                end
            end
            ST_FETCH: begin
                // ROM data for rom_addr_q appears during the following cycle.
                state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (word.pitch == PITCH_END) begin
                    if (loop_en) begin
                        rom_addr_d = '0;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        led_d     = '0;
                        tone_en_d = 1'b0;
                    end
                end else if (word.ms == '0) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                    state_d    = ST_FETCH;
                end else begin
                    half_d    = table_half;
                    led_d     = {2'b00, word.pitch};
                    tone_en_d = (word.pitch != PITCH_REST);
                    ms_d      = word.ms;
                    tick_d    = '0;
                    tpm_d     = tpm_eff;
                    state_d   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    tpm_d  = tpm_eff;
                    ms_d   = ms_q - MS_W'(1);
                    if (ms_q == MS_W'(1)) begin
                        tone_en_d = 1'b0;
                        if (GAP_MS != 0) begin
                            ms_d    = MS_W'(GAP_MS);
                            state_d = ST_GAP;
                        end else begin
                            rom_addr_d = rom_addr_q + ADDR_W'(1);
                            state_d    = ST_FETCH;
                        end
                    end
                end else begin
                    tick_d = tick_q + TPM_W'(1);
                end
            end
            ST_GAP: begin
                if (tick_wrap) begin
                    tick_d = '0;
                    tpm_d  = tpm_eff;
                    ms_d   = ms_q - MS_W'(1);
                    if (ms_q == MS_W'(1)) begin
                        rom_addr_d = rom_addr_q + ADDR_W'(1);
                        state_d    = ST_FETCH;
                    end
                end else begin
                    tick_d = tick_q + TPM_W'(1);
                end
            end
            ST_DONE: begin
                rom_addr_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Stop overrides everything, including a start in the same cycle.
        if (stop) begin
            state_d    = ST_IDLE;
            rom_addr_d = '0;
            tone_en_d  = 1'b0;
            led_d      = '0;
            done_d     = 1'b0;
            half_d     = half_q;
            tick_d     = '0;
            ms_d       = '0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            rom_addr_q <= '0;
            tone_en_q  <= 1'b0;
            half_q     <= '0;
            led_q      <= '0;
            done_q     <= 1'b0;
            tick_q     <= '0;
            tpm_q      <= '0;
            ms_q       <= '0;
        end else begin
            state_q    <= state_d;
            rom_addr_q <= rom_addr_d;
            tone_en_q  <= tone_en_d;
            half_q     <= half_d;
            led_q      <= led_d;
            done_q     <= done_d;
            tick_q     <= tick_d;
            tpm_q      <= tpm_d;
            ms_q       <= ms_d;
        end
    end

    assign rom_addr         = rom_addr_q;
    assign tone_en          = tone_en_q;
    assign tone_half_period = half_q;
    assign led              = led_q;
    assign done             = done_q;
    assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer. A song-level reference model expands
// the ROM into the expected output timeline; the monitor run-length-encodes the
// DUT outputs and compares each finished segment against the scoreboard.
module tb_music_sequencer;

    localparam int GAP = 2;

    typedef struct packed {
        logic [7:0]  addr;
        logic        te;
        logic [15:0] half;
        logic [7:0]  led;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct {
        obs_t o;
        int   len;
        bit   chk_len;
    } seg_t;

    logic        clk = 1'b0;
    logic        rst_n, start, stop, loop_en;
    logic [15:0] tpm;
    logic [7:0]  rom_addr;
    logic [15:0] rom_data;
    logic        tone_en;
    logic [15:0] tone_half_period;
    logic [7:0]  led;
    logic        busy, done;

    logic [15:0] rom [256];

    int   checks   = 0;
    int   failures = 0;
    seg_t exp_q [$];
    obs_t trace [$];
    logic [15:0] model_half = '0;

    bit   mon_en   = 1'b0;
    bit   have_cur = 1'b0;
    obs_t cur;
    int   cur_len  = 0;

    always #5 clk = ~clk;

    music_sequencer #(.ADDR_W(8), .GAP_MS(GAP), .TPM_W(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .stop             (stop),
        .loop_en          (loop_en),
        .ticks_per_milli  (tpm),
        .rom_addr         (rom_addr),
        .rom_data         (rom_data),
        .tone_en          (tone_en),
        .tone_half_period (tone_half_period),
        .led              (led),
        .busy             (busy),
        .done             (done)
    );

    // Synchronous song ROM: data one cycle after the address.
    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check(input string name, input bit ok, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic logic [15:0] ref_half(input int p);
        int base [12];
        base = '{45868, 43293, 40864, 38570, 36406, 34362,
                 32432, 30612, 28895, 27273, 25742, 24297};
        if (p == 0 || p == 63) return 16'd0;
        return 16'(base[(p - 1) % 12] / (1 << ((p - 1) / 12)));
    endfunction

    // Expand the current ROM into one expected output value per clock cycle,
    // starting with the first cycle after start is sampled.
    task automatic gen_trace(input int limit);
        int addr, tp, pitch, ms;
        logic [15:0] half;
        logic [7:0]  ld;
        obs_t o;
        addr = 0;
        half = model_half;
        ld   = 8'd0;
        tp   = (tpm == 16'd0) ? 1 : int'(tpm);
        trace.delete();
        while (trace.size() < limit) begin
            o = '{addr: 8'(addr), te: 1'b0, half: half, led: ld, busy: 1'b1, done: 1'b0};
            trace.push_back(o);
            trace.push_back(o);
            pitch = int'(rom[addr][15:10]);
            ms    = int'(rom[addr][9:0]);
            if (pitch == 63) begin
                if (loop_en) begin
                    addr = 0;
                    continue;
                end
                trace.push_back('{addr: 8'(addr), te: 1'b0, half: half, led: 8'd0,
                                  busy: 1'b1, done: 1'b1});
                break;
            end
            if (ms == 0) begin
                addr = (addr + 1) % 256;
                continue;
            end
            half = ref_half(pitch);
            ld   = 8'(pitch);
            repeat (ms * tp)
                trace.push_back('{addr: 8'(addr), te: (pitch != 0), half: half, led: ld,
                                  busy: 1'b1, done: 1'b0});
            repeat (GAP * tp)
                trace.push_back('{addr: 8'(addr), te: 1'b0, half: half, led: ld,
                                  busy: 1'b1, done: 1'b0});
            addr = (addr + 1) % 256;
        end
    endtask

    // Play the current ROM. stop_at>0 aborts (stop, or reset when use_rst)
    // so that only the first stop_at cycles of the song are seen.
    task automatic run_song(input int stop_at, input bit use_rst);
        int   k, i, j;
        obs_t idle_o;
        gen_trace(stop_at > 0 ? stop_at : 20000);
        while (stop_at > 0 && trace.size() > stop_at) void'(trace.pop_back());
        k = trace.size();
        if (use_rst) idle_o = '0;
        else idle_o = '{addr: 8'd0, te: 1'b0, half: trace[k-1].half, led: 8'd0,
                        busy: 1'b0, done: 1'b0};
        i = 0;
        while (i < k) begin
            j = i;
            while (j < k && trace[j] == trace[i]) j++;
            exp_q.push_back('{o: trace[i], len: j - i, chk_len: 1'b1});
            i = j;
        end
        exp_q.push_back('{o: idle_o, len: 0, chk_len: 1'b0});
        model_half = idle_o.half;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        if (stop_at > 0) begin
            repeat (k - 1) @(negedge clk);
            if (use_rst) begin
                rst_n = 1'b0;
                repeat (3) @(negedge clk);
            end else begin
                stop = 1'b1;
                @(negedge clk);
            end
            rst_n = 1'b1;
            stop  = 1'b0;
            repeat (4) @(negedge clk);
        end else begin
            repeat (k + 4) @(negedge clk);
        end
    endtask

    // Monitor: close a segment whenever any observed output changes.
    always @(negedge clk) begin
        obs_t now;
        seg_t e;
        if (mon_en) begin
            now = '{addr: rom_addr, te: tone_en, half: tone_half_period, led: led,
                    busy: busy, done: done};
            if (!have_cur) begin
                cur      = now;
                cur_len  = 1;
                have_cur = 1'b1;
            end else if (now !== cur) begin
                if (exp_q.size() == 0) begin
                    check("segment_unexpected", 1'b0,
                          $sformatf("got %h len %0d, scoreboard empty", cur, cur_len));
                end else begin
                    e = exp_q.pop_front();
                    check("segment", (cur === e.o) && (!e.chk_len || cur_len == e.len),
                          $sformatf("got %h len %0d, want %h len %0d",
                                    cur, cur_len, e.o, e.len));
                end
                cur     = now;
                cur_len = 1;
            end else begin
                cur_len++;
            end
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        loop_en = 1'b0;
        tpm     = 16'd1;
        for (int i = 0; i < 256; i++) rom[i] = 16'hFC00;
        exp_q.push_back('{o: '0, len: 0, chk_len: 1'b0});
        repeat (3) @(posedge clk);
        @(negedge clk);
        mon_en = 1'b1;
        rst_n  = 1'b1;
        repeat (2) @(negedge clk);

        // Reset held 3 cycles in the middle of a note.
        rom[0] = {6'd5, 10'd3}; rom[1] = 16'hFC00; tpm = 16'd4;
        run_song(7, 1'b1);

        // Single note, gap, done pulse.
        run_song(0, 1'b0);

        // Rest, zero-length entry, short note.
        rom[0] = {6'd0, 10'd2}; rom[1] = {6'd7, 10'd0}; rom[2] = {6'd9, 10'd1};
        rom[3] = 16'hFC00; tpm = 16'd2;
        run_song(0, 1'b0);

        // Looping song, then stop.
        rom[0] = {6'd3, 10'd1}; rom[1] = 16'hFC05; tpm = 16'd1; loop_en = 1'b1;
        run_song(40, 1'b0);
        loop_en = 1'b0;

        // ticks_per_milli of zero behaves as one.
        rom[0] = {6'd12, 10'd2}; rom[1] = 16'hFC00; tpm = 16'd0;
        run_song(0, 1'b0);

        // Start and stop together while idle: nothing happens.
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
        repeat (5) @(negedge clk);

        // Full ROM without an end marker: address wraps 255 -> 0.
        for (int i = 0; i < 256; i++) rom[i] = {6'($urandom_range(1, 62)), 10'd1};
        tpm = 16'd1;
        run_song(1300, 1'b0);

        // Randomized songs.
        for (int t = 0; t < 30; t++) begin
            int len, mode;
            len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                logic [5:0] p;
                logic [9:0] m;
                p = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom_range(1, 62));
                m = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom_range(1, 3));
                rom[i] = {p, m};
            end
            rom[len] = {6'd63, 10'($urandom_range(0, 1023))};
            tpm      = 16'($urandom_range(0, 3));
            loop_en  = ($urandom_range(0, 2) == 0);
            mode     = int'($urandom_range(0, 3));
            if (loop_en) run_song(int'($urandom_range(5, 80)), ($urandom_range(0, 7) == 0));
            else if (mode == 0) run_song(int'($urandom_range(1, 40)), $urandom_range(0, 1) == 1);
            else run_song(0, 1'b0);
        end
        loop_en = 1'b0;

        repeat (5) @(negedge clk);
        check("scoreboard_drain", exp_q.size() == 1,
              $sformatf("got %0d entries left, want 1", exp_q.size()));
        if (exp_q.size() >= 1)
            check("final_idle", cur === exp_q[0].o,
                  $sformatf("got %h, want %h", cur, exp_q[0].o));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
